// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the FP32 datapath blocks.
//   - FP32 field widths and exponent bias
//   - fp32_t packed view of an FP32 word (sign, exp, mant)
//   - INT32 saturation limits
//   - FP_TO_INT_LAT: pipeline depth of fp_to_int
// No ports (package).
// ----------------------------------------------------------------------------
package fp_pkg;

   localparam int FP_EXP_W      = 8;
   localparam int FP_MANT_W     = 23;
   localparam int FP_SIG_W      = FP_MANT_W + 1;
   localparam int FP_BIAS       = 127;

   localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
   // -2^31 in FP32: the only sh = 31 value that still fits in INT32
   localparam logic [31:0] FP32_NEG_2P31 = 32'hCF00_0000;

   localparam int FP_TO_INT_LAT = 4;

   typedef struct packed {
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_MANT_W-1:0] mant;
   } fp32_t;

endpackage

// File: rtl/fp_rshift_sticky.sv
// ----------------------------------------------------------------------------
// fp_rshift_sticky
// Combinational right shift of a 24-bit significand with guard/sticky capture.
// Ports:
//   i_val [23:0]  significand to shift
//   i_amt [4:0]   shift amount (0..31; 24 and above shift everything out)
//   o_val [23:0]  shifted significand
//   o_g           guard: first bit below the retained value
//   o_s           sticky: OR of every discarded bit below the guard
// ----------------------------------------------------------------------------
module fp_rshift_sticky
   import fp_pkg::*;
(
   input  logic [FP_SIG_W-1:0] i_val,
   input  logic [4:0]          i_amt,
   output logic [FP_SIG_W-1:0] o_val,
   output logic                o_g,
   output logic                o_s
);

   // Shifting into a double-width word keeps every discarded bit visible in
   // the low half, so guard and sticky fall out as simple slices.
   logic [2*FP_SIG_W-1:0] w_ext;

   assign w_ext = {i_val, {FP_SIG_W{1'b0}}} >> i_amt;
   assign o_val = w_ext[2*FP_SIG_W-1:FP_SIG_W];
   assign o_g   = w_ext[FP_SIG_W-1];
   assign o_s   = |w_ext[FP_SIG_W-2:0];

endmodule

// File: rtl/fp_to_int.sv
// ----------------------------------------------------------------------------
// fp_to_int
// Four-stage FP32 -> signed INT32 converter, one word per cycle, fixed
// latency of FP_TO_INT_LAT cycles.
//   stage 1: unpack + classify (zero, NaN, overflow/Inf, exact -2^31)
//   stage 2: align significand into a 32-bit magnitude (G/S captured)
//   stage 3: round (or plain register)
//   stage 4: apply sign / saturation and register outputs
// Build option: FP_TO_INT_ROUND_EN
//   defined   -> round-to-nearest-even
//   undefined -> truncate toward zero, no incrementer
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   in_vld   operand valid
//   a        FP32 operand
//   out_vld  result valid
//   out      INT32 result
//   ovf      magnitude out of range (incl. +/-Inf), result saturated
//   inv      operand was NaN
// Handshake: valid-only stream, no ready. A word with in_vld high is always
// accepted; its result appears with out_vld high exactly FP_TO_INT_LAT cycles
// later. out/ovf/inv are meaningful only while out_vld is high.
// ----------------------------------------------------------------------------
module fp_to_int
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_vld,
   input  logic [31:0] a,
   output logic        out_vld,
   output logic [31:0] out,
   output logic        ovf,
   output logic        inv
);

   // ---------------- stage 1: unpack and classify ----------------
   fp32_t             w_a;
   logic signed [8:0] w_sh;
   logic              w_exp_max;
   logic              w_mant_nz;
   logic              w_is_nan;
   logic              w_is_inf;
   logic              w_is_min;
   logic              w_is_zero;
   logic              w_is_ovf;

   assign w_a       = a;
   assign w_sh      = signed'({1'b0, w_a.exp}) - signed'(9'(FP_BIAS));
   assign w_exp_max = (w_a.exp == '1);
   assign w_mant_nz = |w_a.mant;
   assign w_is_nan  = w_exp_max & w_mant_nz;
   assign w_is_inf  = w_exp_max & ~w_mant_nz;
   assign w_is_min  = (a == FP32_NEG_2P31);
   // sh <= -2 means |x| < 0.5, which is zero in both rounding modes
   assign w_is_zero = (w_a.exp == '0) | (w_sh <= -9'sd2);
   assign w_is_ovf  = w_is_inf | (~w_exp_max & (w_sh >= 9'sd31) & ~w_is_min);

   logic                 r1_sign;
   logic signed [8:0]    r1_sh;
   logic [FP_MANT_W-1:0] r1_mant;
   logic                 r1_zero;
   logic                 r1_nan;
   logic                 r1_ovf;
   logic                 r1_min;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_sign <= 1'b0;
         r1_sh   <= '0;
         r1_mant <= '0;
         r1_zero <= 1'b0;
         r1_nan  <= 1'b0;
         r1_ovf  <= 1'b0;
         r1_min  <= 1'b0;
      end else begin
         r1_sign <= w_a.sign;
         r1_sh   <= w_sh;
         r1_mant <= w_a.mant;
         r1_zero <= w_is_zero;
         r1_nan  <= w_is_nan;
         r1_ovf  <= w_is_ovf;
         r1_min  <= w_is_min;
      end
   end

   // ---------------- stage 2: align ----------------
   // Non-special words reaching here have sh in [-1, 30].
   logic [FP_SIG_W-1:0] w_sig;
   logic                w_special;
   logic                w_big;
   logic [4:0]          w_lsh_amt;
   logic [4:0]          w_rsh_amt;
   logic [31:0]         w_lsh_val;
   logic [FP_SIG_W-1:0] w_rsh_val;

   assign w_sig     = {1'b1, r1_mant};
   assign w_special = r1_zero | r1_nan | r1_ovf | r1_min;
   assign w_big     = (r1_sh >= 9'sd23);
   // Only the low 5 bits matter: sh-23 is 0..7 when big, 23-sh is 1..24 else
   assign w_lsh_amt = r1_sh[4:0] - 5'd23;
   assign w_rsh_amt = 5'd23 - r1_sh[4:0];
   assign w_lsh_val = {8'd0, w_sig} << w_lsh_amt;

   logic [31:0] r2_mag;
   logic        r2_sign;
   logic        r2_nan;
   logic        r2_ovf;
   logic        r2_min;

`ifdef FP_TO_INT_ROUND_EN
   logic w_g;
   logic w_s;
   logic r2_g;
   logic r2_s;

   fp_rshift_sticky u_rshift (
      .i_val (w_sig),
      .i_amt (w_rsh_amt),
      .o_val (w_rsh_val),
      .o_g   (w_g),
      .o_s   (w_s)
   );
`else
   fp_rshift_sticky u_rshift (
      .i_val (w_sig),
      .i_amt (w_rsh_amt),
      .o_val (w_rsh_val),
      .o_g   (),
      .o_s   ()
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_mag  <= '0;
         r2_sign <= 1'b0;
         r2_nan  <= 1'b0;
         r2_ovf  <= 1'b0;
         r2_min  <= 1'b0;
`ifdef FP_TO_INT_ROUND_EN
         r2_g    <= 1'b0;
         r2_s    <= 1'b0;
`endif
      end else begin
         r2_sign <= r1_sign;
         r2_nan  <= r1_nan;
         r2_ovf  <= r1_ovf;
         r2_min  <= r1_min;
         // Special classes carry a clean zero magnitude so rounding cannot
         // disturb them; stage 4 substitutes their final value.
         if (w_special) begin
            r2_mag <= '0;
         end else if (w_big) begin
            r2_mag <= w_lsh_val;
         end else begin
            r2_mag <= {8'd0, w_rsh_val};
         end
`ifdef FP_TO_INT_ROUND_EN
         r2_g <= ~w_special & ~w_big & w_g;
         r2_s <= ~w_special & ~w_big & w_s;
`endif
      end
   end

   // ---------------- stage 3: round ----------------
   // Largest aligned magnitude is 2^31-128, so the increment never overflows.
   logic [31:0] r3_mag;
   logic        r3_sign;
   logic        r3_nan;
   logic        r3_ovf;
   logic        r3_min;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3_mag  <= '0;
         r3_sign <= 1'b0;
         r3_nan  <= 1'b0;
         r3_ovf  <= 1'b0;
         r3_min  <= 1'b0;
      end else begin
`ifdef FP_TO_INT_ROUND_EN
         r3_mag  <= r2_mag + {31'd0, r2_g & (r2_s | r2_mag[0])};
`else
         r3_mag  <= r2_mag;
`endif
         r3_sign <= r2_sign;
         r3_nan  <= r2_nan;
         r3_ovf  <= r2_ovf;
         r3_min  <= r2_min;
      end
   end

   // ---------------- stage 4: sign, saturate, output ----------------
   logic [31:0] r_out;
   logic        r_ovf;
   logic        r_inv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0;
         r_ovf <= 1'b0;
         r_inv <= 1'b0;
      end else if (r3_nan) begin
         r_out <= INT32_MAX;
         r_ovf <= 1'b0;
         r_inv <= 1'b1;
      end else if (r3_ovf) begin
         r_out <= r3_sign ? INT32_MIN : INT32_MAX;
         r_ovf <= 1'b1;
         r_inv <= 1'b0;
      end else if (r3_min) begin
         r_out <= INT32_MIN;
         r_ovf <= 1'b0;
         r_inv <= 1'b0;
      end else begin
         r_out <= r3_sign ? (~r3_mag + 32'd1) : r3_mag;
         r_ovf <= 1'b0;
         r_inv <= 1'b0;
      end
   end

   // ---------------- valid pipeline ----------------
   logic [FP_TO_INT_LAT-1:0] r_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else begin
         r_vld <= {r_vld[FP_TO_INT_LAT-2:0], in_vld};
      end
   end

   assign out_vld = r_vld[FP_TO_INT_LAT-1];
   assign out     = r_out;
   assign ovf     = r_ovf;
   assign inv     = r_inv;

endmodule

// File: tb/tb_fp_to_int.sv
// ----------------------------------------------------------------------------
// tb_fp_to_int
// Directed + random stimulus for fp_to_int. Each accepted word pushes
// {due_cycle, out, ovf, inv} to exp_q; the negedge monitor pops and compares
// whenever out_vld is high, and flags missing or unexpected results.
// ----------------------------------------------------------------------------
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_vld = 1'b0;
  logic [31:0] a = '0;
  logic        out_vld;
  logic [31:0] out;
  logic        ovf;
  logic        inv;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // entry: {due_cycle[65:34], out[33:2], ovf[1], inv[0]}
  logic [65:0] exp_q[$];

  fp_to_int dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .a       (a),
    .out_vld (out_vld),
    .out     (out),
    .ovf     (ovf),
    .inv     (inv)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check helpers ----------------
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, expv, $time);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, expv, $time);
      $error("check %s did not match", tag);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] word, input logic [31:0] eo,
                      input logic eovf, input logic einv);
    @(negedge clk);
    a      = word;
    in_vld = 1'b1;
    exp_q.push_back({cyc + 32'd4, eo, eovf, einv});
  endtask

  task automatic idle();
    @(negedge clk);
    in_vld = 1'b0;
    a      = $urandom;
  endtask

  // exact int -> FP32 for |n| < 2^24
  function automatic logic [31:0] int_to_fp(input int n);
    logic [31:0] m;
    logic [31:0] s;
    int          p;
    if (n == 0) return 32'h0;
    m = (n < 0) ? 32'(-n) : 32'(n);
    p = 31;
    while (!m[p]) p--;
    s = m << (23 - p);
    return {(n < 0), 8'(127 + p), s[22:0]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [65:0] e;
    if (out_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check1("unexpected_vld", out_vld, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check32("latency", cyc, e[65:34]);
        check32("out", out, e[33:2]);
        check1("ovf", ovf, e[1]);
        check1("inv", inv, e[0]);
      end
    end else if (exp_q.size() > 0 && exp_q[0][65:34] <= cyc) begin
      check1("missing_vld", out_vld, 1'b1);
      void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] stream_w[8];
  logic [31:0] stream_e[8];
  logic [7:0]  pattern;
  int          n;
  int          guard;

  initial begin
    // reset and reset values
    #2 rst_n = 1'b0;
    #1;
    check1("rst_out_vld", out_vld, 1'b0);
    check32("rst_out", out, 32'h0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_inv", inv, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // basic conversion
    send(32'h40490FDB, 32'h0000_0003, 1'b0, 1'b0);
    send(32'hC0490FDB, 32'hFFFF_FFFD, 1'b0, 1'b0);

    // rounding
`ifdef FP_TO_INT_ROUND_EN
    send(32'h40600000, 32'h0000_0004, 1'b0, 1'b0);
    send(32'h40200000, 32'h0000_0002, 1'b0, 1'b0);
    send(32'hC0600000, 32'hFFFF_FFFC, 1'b0, 1'b0);
    send(32'h3F400000, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h3F000000, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h3FC00000, 32'h0000_0002, 1'b0, 1'b0);
`else
    send(32'h40600000, 32'h0000_0003, 1'b0, 1'b0);
    send(32'h40200000, 32'h0000_0002, 1'b0, 1'b0);
    send(32'hC0600000, 32'hFFFF_FFFD, 1'b0, 1'b0);
    send(32'h3F400000, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h3F000000, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h3FC00000, 32'h0000_0001, 1'b0, 1'b0);
`endif

    // range limits
    send(32'hCF000000, 32'h8000_0000, 1'b0, 1'b0);
    send(32'h4F000000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    send(32'h4EFFFFFF, 32'h7FFF_FF80, 1'b0, 1'b0);
    send(32'hCF000001, 32'h8000_0000, 1'b1, 1'b0);
    send(32'hCF800000, 32'h8000_0000, 1'b1, 1'b0);
    send(32'hFF800000, 32'h8000_0000, 1'b1, 1'b0);
    send(32'h7F800000, 32'h7FFF_FFFF, 1'b1, 1'b0);

    // special values
    send(32'h7FC00000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    send(32'hFFC00001, 32'h7FFF_FFFF, 1'b0, 1'b1);
    send(32'h00000001, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h80000000, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h00000000, 32'h0000_0000, 1'b0, 1'b0);
    idle();

    // streaming with gaps: pattern applied MSB first
    stream_w = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h42C80000,
                 32'h47800000, 32'hC0E00000, 32'h41200000, 32'hC2C80000};
    stream_e = '{32'd1, 32'd2, 32'hFFFF_FFFF, 32'd100,
                 32'd65536, 32'hFFFF_FFF9, 32'd10, 32'hFFFF_FF9C};
    pattern  = 8'b1101_1011;
    for (int i = 7; i >= 0; i--) begin
      if (pattern[i]) send(stream_w[7 - i], stream_e[7 - i], 1'b0, 1'b0);
      else            idle();
    end
    idle();

    // random exact integers
    repeat (24) begin
      n = int'($urandom_range(0, 32'h00FF_FFFF));
      if ($urandom_range(0, 1) == 1) n = -n;
      send(int_to_fp(n), 32'(n), 1'b0, 1'b0);
    end
    idle();

    // reset with three words in flight
    repeat (6) idle();
    for (int i = 0; i < 5; i++) send(32'h40400000, 32'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check1("vld_before_rst", out_vld, 1'b1);
    #1;
    rst_n  = 1'b0;
    in_vld = 1'b0;
    exp_q.delete();
    #1;
    check1("rst_async_vld", out_vld, 1'b0);
    check32("rst_async_out", out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) idle();
    send(32'h42C80000, 32'd100, 1'b0, 1'b0);
    idle();

    // drain with bound
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      idle();
      guard++;
    end
    repeat (2) idle();
    check32("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
